// File: rtl/serial_prefix_sum_ctrl.sv
// serial_prefix_sum_ctrl
//
// Bit-serial adder controller. One sum cell and one carry register are
// reused for every bit position of the operand pair, processing one bit per
// clock, starting at the LSB. Operands arrive over a valid/ready handshake.
// The result {cout, sum} = a + b + cin leaves over a second valid/ready
// handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand pair valid
//   in_ready   controller can accept operands (registered)
//   a, b       operands, WIDTH bits each
//   cin        carry into bit 0
//   out_valid  result valid (registered)
//   out_ready  consumer accepts result
//   sum        low WIDTH bits of a + b + cin (registered)
//   cout       carry out of bit WIDTH-1 (registered)
//   busy       high while an operation is running or waiting to be taken
module serial_prefix_sum_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t             state_q,     state_d;
    logic [WIDTH-1:0]   a_q,         a_d;
    logic [WIDTH-1:0]   b_q,         b_d;
    logic               carry_q,     carry_d;
    logic [CNT_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [WIDTH-1:0]   sum_q,       sum_d;
    logic               cout_q,      cout_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q,      busy_d;

    logic               bit_p;
    logic               bit_g;
    logic               bit_s;
    logic               carry_next;

    // The shared sum cell. It always looks at the bit selected by the
    // counter; its result is only used while the controller is in RUN.
    always_comb begin
        bit_p      = a_q[bit_cnt_q] ^ b_q[bit_cnt_q];
        bit_g      = a_q[bit_cnt_q] & b_q[bit_cnt_q];
        bit_s      = bit_p ^ carry_q;
        carry_next = bit_g | (bit_p & carry_q);
    end

    // Next-state logic. The handshake outputs are derived from the next
    // state so that they come straight out of flops and never see a
    // combinational path from the inputs.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        carry_d   = carry_q;
        bit_cnt_d = bit_cnt_q;
        sum_d     = sum_q;
        cout_d    = cout_q;

        case (state_q)
            IDLE: begin
                // in_ready is always high in IDLE, so in_valid alone is the accept.
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    carry_d   = cin;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                // Bits above the counter keep whatever value they held before.
                sum_d[bit_cnt_q] = bit_s;
                carry_d          = carry_next;
                if (bit_cnt_q == LAST_BIT) begin
                    cout_d  = carry_next;
                    state_d = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers. Reset wins over any handshake and throws
    // away a partially computed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            bit_cnt_q   <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            bit_cnt_q   <= bit_cnt_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign busy      = busy_q;

endmodule
